// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Multi-cycle instruction-fetch controller. Owns the architectural PC, issues
// one instruction-memory read at a time, holds the returned word for decode
// behind a valid/ready handshake, and applies branch/jump redirects.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   imem_req        read request, held until imem_ack
//   imem_addr       registered read address, stable while imem_req=1
//   imem_ack        read data valid this cycle
//   imem_rdata      instruction word from memory
//   instr_valid     instr/instr_pc valid to decode
//   instr_ready     decode accepts instr this cycle
//   instr           held instruction word
//   instr_pc        address of the held instruction
//   redirect_valid  control-flow change request (single-cycle pulse)
//   redirect_sel    01 base+imm, 10 alu&~1, 00/11 ignored
//   redirect_base   PC of the redirecting instruction
//   redirect_imm    immediate offset
//   redirect_alu    absolute target from the ALU
//   trap            single-cycle pulse on a misaligned redirect
//
// Build option
//   MISALIGN_TRAP_EN  when defined, a misaligned redirect target pulses trap
//                     and loads TRAP_VECTOR; when undefined the target is
//                     word-aligned by clearing bits [1:0] and trap is tied 0.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned       DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [DWIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [DWIDTH-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DWIDTH-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DWIDTH-1:0] instr,
    output logic [DWIDTH-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_sel,
    input  logic [DWIDTH-1:0] redirect_base,
    input  logic [DWIDTH-1:0] redirect_imm,
    input  logic [DWIDTH-1:0] redirect_alu,
    output logic              trap
);

    typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} state_t;

    state_t            state, state_next;
    logic [DWIDTH-1:0] pc, pc_next, addr_next;
    logic              load_instr;
    logic              taken;
    logic [DWIDTH-1:0] raw_target;
    logic [DWIDTH-1:0] jump_pc;

    assign taken = redirect_valid & ((redirect_sel == 2'b01) | (redirect_sel == 2'b10));

    always_comb begin
        raw_target = '0;
        case (redirect_sel)
            2'b01:   raw_target = redirect_base + redirect_imm;
            2'b10:   raw_target = redirect_alu & ~DWIDTH'(1);
            default: raw_target = '0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    logic trap_q;

    assign misaligned = (raw_target[1:0] != 2'b00);
    assign jump_pc    = misaligned ? TRAP_VECTOR : raw_target;
    assign trap       = trap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trap_q <= 1'b0;
        else        trap_q <= taken & misaligned;
    end
`else
    assign jump_pc = raw_target & ~DWIDTH'(3);
    assign trap    = 1'b0;
`endif

    assign imem_req    = (state == REQ) | (state == DRAIN);
    // A redirect in HOLD kills the held instruction in the same cycle.
    assign instr_valid = (state == HOLD) & ~taken;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        addr_next  = imem_addr;
        load_instr = 1'b0;
        case (state)
            BOOT: begin
                state_next = REQ;
                pc_next    = taken ? jump_pc : pc;
                addr_next  = taken ? jump_pc : pc;
            end
            REQ: begin
                if (imem_ack) begin
                    if (taken) begin
                        // Response belongs to the wrong path; refetch at target.
                        pc_next   = jump_pc;
                        addr_next = jump_pc;
                    end else begin
                        load_instr = 1'b1;
                        pc_next    = pc + DWIDTH'(4);
                        state_next = HOLD;
                    end
                end else if (taken) begin
                    // The bus request cannot be withdrawn; wait it out.
                    pc_next    = jump_pc;
                    state_next = DRAIN;
                end
            end
            HOLD: begin
                if (taken) begin
                    pc_next    = jump_pc;
                    addr_next  = jump_pc;
                    state_next = REQ;
                end else if (instr_ready) begin
                    addr_next  = pc;
                    state_next = REQ;
                end
            end
            DRAIN: begin
                pc_next = taken ? jump_pc : pc;
                if (imem_ack) begin
                    addr_next  = pc_next;
                    state_next = REQ;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_VECTOR;
            imem_addr <= RESET_VECTOR;
            instr     <= '0;
            instr_pc  <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            imem_addr <= addr_next;
            if (load_instr) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed scenarios with literal expectations followed by a randomized run.
// A transaction-level reference model (pending PC, bus-busy flag, stale-data
// flag, held instruction) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_sel = 2'b00;
    logic [31:0] redirect_base = '0;
    logic [31:0] redirect_imm = '0;
    logic [31:0] redirect_alu = '0;
    logic        trap;

    fetch_sequencer #(.DWIDTH(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .redirect_base  (redirect_base),
        .redirect_imm   (redirect_imm),
        .redirect_alu   (redirect_alu),
        .trap           (trap)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_boot;      // first cycle after reset, nothing issued yet
    bit          m_busy;      // a read is on the bus
    bit          m_stale;     // the outstanding read's data must be dropped
    bit          m_hold;      // an instruction is waiting for decode
    bit          m_trap;      // trap pulse expected this cycle
    logic [31:0] m_pc;        // next address to fetch
    logic [31:0] m_addr;      // address of the outstanding read
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_taken();
        return redirect_valid && (redirect_sel == 2'd1 || redirect_sel == 2'd2);
    endfunction

    function automatic logic [31:0] raw_target();
        if (redirect_sel == 2'd1) return redirect_base + redirect_imm;
        return {redirect_alu[31:1], 1'b0};
    endfunction

    function automatic bit target_traps();
`ifdef MISALIGN_TRAP_EN
        return raw_target() % 4 != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] target();
        if (target_traps()) return TV;
        return raw_target() & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        m_boot = 1; m_busy = 0; m_stale = 0; m_hold = 0; m_trap = 0;
        m_pc = RV; m_addr = RV; m_instr = '0; m_ipc = '0;
    endtask

    // Apply inputs for the coming edge and compare all outputs with the model.
    task automatic drive(input bit ack, input bit rdy, input bit rv, input logic [1:0] sel,
                         input logic [31:0] b, input logic [31:0] i, input logic [31:0] a);
        @(negedge clk);
        imem_ack       = ack;
        imem_rdata     = ack ? word(m_addr) : $urandom;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_sel   = sel;
        redirect_base  = b;
        redirect_imm   = i;
        redirect_alu   = a;
        #1;
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_busy});
        if (m_busy) chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_hold && !is_taken()});
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("trap", {31'd0, trap}, {31'd0, m_trap});
    endtask

    // Advance the model across the coming clock edge.
    task automatic commit();
        bit          tk;
        logic [31:0] t;
        tk = is_taken();
        t  = target();
        m_trap = tk && target_traps();
        if (m_boot) begin
            m_boot = 0;
            if (tk) m_pc = t;
            m_busy = 1; m_stale = 0; m_addr = m_pc;
        end else if (m_busy) begin
            if (imem_ack) begin
                if (tk) m_pc = t;
                if (tk || m_stale) begin
                    m_stale = 0; m_addr = m_pc;
                end else begin
                    m_instr = imem_rdata; m_ipc = m_addr;
                    m_pc = m_addr + 32'd4;
                    m_busy = 0; m_hold = 1;
                end
            end else if (tk) begin
                m_pc = t; m_stale = 1;
            end
        end else if (m_hold) begin
            if (tk) m_pc = t;
            if (tk || instr_ready) begin
                m_hold = 0; m_busy = 1; m_addr = m_pc;
            end
        end
    endtask

    task automatic step(input bit ack, input bit rdy, input bit rv, input logic [1:0] sel,
                        input logic [31:0] b, input logic [31:0] i, input logic [31:0] a);
        drive(ack, rdy, rv, sel, b, i, a);
        commit();
    endtask

    // Assert reset asynchronously, check outputs immediately, release after an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 0; instr_ready = 0; redirect_valid = 0; redirect_sel = 0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        model_reset();
        do_reset();

        // Sequential fetch with one-cycle ack and ready=1
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        commit();
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("fetch0_addr", imem_addr, 32'h0);
        commit();
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("hold0_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold0_pc", instr_pc, 32'h0);
        chk("hold0_instr", instr, word(32'h0));
        commit();
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("fetch1_addr", imem_addr, 32'h4);
        chk("fetch1_valid", {31'd0, instr_valid}, 32'd0);
        commit();

        // Decode stalls for five cycles
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_pc", instr_pc, 32'h4);
            commit();
        end
        step(0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("resume_addr", imem_addr, 32'h8);
        commit();

        // Redirect while holding: base+imm
        drive(0, 1, 1, 2'b01, 32'h20, 32'h40, 0);
        chk("kill_valid", {31'd0, instr_valid}, 32'd0);
        commit();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("redir_addr", imem_addr, 32'h60);
        commit();

        // Redirect mid-request, ack delayed: drain then refetch
        step(0, 0, 1, 2'b10, 0, 0, 32'h101);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("drain_addr", imem_addr, 32'h60);
        commit();
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("drain_valid", {31'd0, instr_valid}, 32'd0);
        chk("after_drain_addr", imem_addr, 32'h100);
        commit();

        // Redirect coincident with ack, then an ignored sel=11 pulse
        step(1, 0, 1, 2'b01, 32'h200, 32'h10, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("ackredir_valid", {31'd0, instr_valid}, 32'd0);
        chk("ackredir_addr", imem_addr, 32'h210);
        commit();
        step(1, 0, 1, 2'b11, 0, 0, 32'h500);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("sel11_pc", instr_pc, 32'h210);
        chk("sel11_valid", {31'd0, instr_valid}, 32'd1);
        commit();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("sel11_next", imem_addr, 32'h214);
        commit();

        // Misaligned target 0x22
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2'b01, 32'h20, 32'h2, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_trap", {31'd0, trap}, 32'd1);
        chk("mis_addr", imem_addr, TV);
`else
        chk("mis_trap", {31'd0, trap}, 32'd0);
        chk("mis_addr", imem_addr, 32'h20);
`endif
        commit();

        // Reset in the middle of a request
        step(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, RV);
        commit();

        // Randomized traffic with variable memory latency
        lat = 0;
        for (int n = 0; n < 3000; n++) begin
            bit          ack, rdy, rv;
            logic [1:0]  sel;
            logic [31:0] b, i, a;
            if (n % 700 == 699) begin
                @(negedge clk);
                #1;
                do_reset();
                lat = 0;
            end
            ack = 0;
            if (m_busy) begin
                if (lat == 0) begin
                    ack = 1;
                    lat = $urandom_range(0, 3);
                end else begin
                    lat--;
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 5) == 0);
            sel = 2'($urandom_range(0, 3));
            b   = $urandom & 32'h0000_FFFC;
            i   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : ($urandom & 32'h0000_0FFC);
            a   = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFD;
            step(ack, rdy, rv, sel, b, i, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
